// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: producer side (immediate + mode in)
// and consumer side (extended immediate + overflow out), plus the transfer count.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [IN_W-1:0]  const_i;
    logic [1:0]       mode_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [OUT_W-1:0] const_o;
    logic             ovf_o;
    logic [15:0]      xfer_cnt_o;

    // Driver side: decode feeding immediates and the ALU side draining them.
    modport master (
        output in_valid_i, const_i, mode_i, out_ready_i,
        input  in_ready_o, out_valid_o, const_o, ovf_o, xfer_cnt_o
    );

    // Extender side.
    modport slave (
        input  in_valid_i, const_i, mode_i, out_ready_i,
        output in_ready_o, out_valid_o, const_o, ovf_o, xfer_cnt_o
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Multi-mode immediate extender with a registered valid/ready output and a
// 2-entry skid buffer (OREG + SREG). Modes: 00 sign, 01 zero, 10 sign<<SHIFT
// with overflow flag, 11 upper placement.
// Optional: define IMM_EXTEND_STATS_EN to get a wrapping 16-bit count of
// completed output transfers on xfer_cnt_o; otherwise it is tied to zero.
module imm_extend_pipe #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16,
    parameter int SHIFT = 1
) (
    input logic              clk,
    input logic              rst_n,
    imm_extend_pipe_if.slave bus
);

    localparam int WIDE_W = OUT_W + SHIFT;

    typedef enum logic [1:0] {
        MODE_SEXT  = 2'b00,
        MODE_ZEXT  = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_UPPER = 2'b11
    } mode_e;

    // Illegal widths/shift amounts stop elaboration.
    if ((IN_W < 1) || (IN_W > OUT_W) || (SHIFT < 0) || (SHIFT >= OUT_W)) begin : g_param_check
        $error("imm_extend_pipe: need 1 <= IN_W <= OUT_W and 0 <= SHIFT < OUT_W");
    end

    // ------------------------------------------------------------------
    // Extension datapath
    // ------------------------------------------------------------------
    logic signed [IN_W-1:0]   const_s;
    logic signed [WIDE_W-1:0] sext_wide;
    logic        [WIDE_W-1:0] shifted_wide;
    logic        [OUT_W-1:0]  shift_res;
    logic        [OUT_W-1:0]  ext_data;
    logic                     ext_ovf;
    mode_e                    mode;

    assign const_s      = bus.const_i;
    assign mode         = mode_e'(bus.mode_i);
    // Sign-extend to OUT_W+SHIFT bits so the bits shifted past the top are kept.
    assign sext_wide    = WIDE_W'(const_s);
    assign shifted_wide = sext_wide << SHIFT;
    assign shift_res    = shifted_wide[OUT_W-1:0];

    // Select the extended value; overflow means the truncated result no longer
    // sign-extends back to the full shifted value.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ext_data = '0;
        ext_ovf  = 1'b0;
        unique case (mode)
            MODE_SEXT:  ext_data = sext_wide[OUT_W-1:0];
            MODE_ZEXT:  ext_data = OUT_W'(bus.const_i);
            MODE_SHIFT: begin
                ext_data = shift_res;
                ext_ovf  = (shifted_wide != WIDE_W'(signed'(shift_res)));
            end
            MODE_UPPER: ext_data = OUT_W'(bus.const_i) << (OUT_W - IN_W);
            default:    ext_data = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    logic             oreg_valid_q, oreg_valid_d;
    logic [OUT_W-1:0] oreg_data_q,  oreg_data_d;
    logic             oreg_ovf_q,   oreg_ovf_d;
    logic             sreg_valid_q, sreg_valid_d;
    logic [OUT_W-1:0] sreg_data_q,  sreg_data_d;
    logic             sreg_ovf_q,   sreg_ovf_d;
    logic             accept;
    logic             send;

    // in_ready depends only on SREG state, never on out_ready.
    assign accept = bus.in_valid_i & ~sreg_valid_q;
    assign send   = oreg_valid_q & bus.out_ready_i;

    // Next-state: refill OREG from SREG first, else from the input; overflow into SREG.
    always_comb begin
        oreg_valid_d = oreg_valid_q;
        oreg_data_d  = oreg_data_q;
        oreg_ovf_d   = oreg_ovf_q;
        sreg_valid_d = sreg_valid_q;
        sreg_data_d  = sreg_data_q;
        sreg_ovf_d   = sreg_ovf_q;
        if (send) begin
            if (sreg_valid_q) begin
                oreg_data_d  = sreg_data_q;
                oreg_ovf_d   = sreg_ovf_q;
                sreg_valid_d = 1'b0;
            end else if (accept) begin
                oreg_data_d  = ext_data;
                oreg_ovf_d   = ext_ovf;
            end else begin
                oreg_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!oreg_valid_q) begin
                oreg_valid_d = 1'b1;
                oreg_data_d  = ext_data;
                oreg_ovf_d   = ext_ovf;
            end else begin
                sreg_valid_d = 1'b1;
                sreg_data_d  = ext_data;
                sreg_ovf_d   = ext_ovf;
            end
        end
    end

    // State registers, cleared asynchronously.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    // NOTE: data registers are reset too, because const_o/ovf_o must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_valid_q <= 1'b0;
            oreg_data_q  <= '0;
            oreg_ovf_q   <= 1'b0;
            sreg_valid_q <= 1'b0;
            sreg_data_q  <= '0;
            sreg_ovf_q   <= 1'b0;
        end else begin
            oreg_valid_q <= oreg_valid_d;
            oreg_data_q  <= oreg_data_d;
            oreg_ovf_q   <= oreg_ovf_d;
            sreg_valid_q <= sreg_valid_d;
            sreg_data_q  <= sreg_data_d;
            sreg_ovf_q   <= sreg_ovf_d;
        end
    end

    assign bus.in_ready_o  = ~sreg_valid_q;
    assign bus.out_valid_o = oreg_valid_q;
    assign bus.const_o     = oreg_data_q;
    assign bus.ovf_o       = oreg_ovf_q;

`ifdef IMM_EXTEND_STATS_EN
    logic [15:0] xfer_cnt_q;

    // Count completed output transfers; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= 16'h0000;
        end else if (send) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign bus.xfer_cnt_o = xfer_cnt_q;
`else
    assign bus.xfer_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed mode, overflow,
// backpressure and reset cases plus random streaming against a scoreboard.
module tb_imm_extend_pipe;

    localparam int IN_W  = 4;
    localparam int OUT_W = 16;
    localparam int SHIFT = 1;

    typedef struct {
        logic [15:0] data;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;

    imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
    imm_extend_pipe_if #(.IN_W(16),   .OUT_W(16))    bus16 ();

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    imm_extend_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(1)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_err  = 0;
    int   sends  = 0;
    bit   last_acc;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference extension computed with signed integer arithmetic.
    function automatic exp_t ref_ext(input longint c, input int mode, input int in_w,
                                     input int out_w, input int shift);
        exp_t   r;
        longint sv, p, mask, lim;
        mask = (longint'(1) << out_w) - 1;
        lim  = longint'(1) << (out_w - 1);
        sv   = (c >= (longint'(1) << (in_w - 1))) ? c - (longint'(1) << in_w) : c;
        r.ovf = 1'b0;
        case (mode)
            0: r.data = 16'(sv & mask);
            1: r.data = 16'(c);
            2: begin
                p = sv * (longint'(1) << shift);
                r.data = 16'(p & mask);
                r.ovf  = (p < -lim) || (p >= lim);
            end
            default: r.data = 16'((c * (longint'(1) << (out_w - in_w))) & mask);
        endcase
        return r;
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef IMM_EXTEND_STATS_EN
        return 16'(sends);
`else
        return 16'h0000;
`endif
    endfunction

    // One clock of stimulus on the main DUT, scored at the falling edge.
    task automatic cycle(input logic v, input logic [3:0] c, input logic [1:0] m, input logic r);
        exp_t e;
        bit   snd;
        @(negedge clk);
        bus.in_valid_i  = v;
        bus.const_i     = c;
        bus.mode_i      = m;
        bus.out_ready_i = r;
        #1;
        last_acc = v && bus.in_ready_o;
        snd      = bus.out_valid_o && r;
        check("in_ready", 32'(bus.in_ready_o), 32'(sb.size() < 2));
        check("out_valid", 32'(bus.out_valid_o), 32'(sb.size() > 0));
        check("xfer_cnt", 32'(bus.xfer_cnt_o), 32'(exp_cnt()));
        if (snd && sb.size() > 0) begin
            e = sb.pop_front();
            check("data", 32'(bus.const_o), 32'(e.data));
            check("ovf", 32'(bus.ovf_o), 32'(e.ovf));
            sends++;
        end
        if (last_acc) sb.push_back(ref_ext(longint'(c), int'(m), IN_W, OUT_W, SHIFT));
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) cycle(1'b0, 4'h0, 2'b00, 1'b1);
        cycle(1'b0, 4'h0, 2'b00, 1'b1);
        check("drained", 32'(bus.out_valid_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   acc_cnt;
        logic [15:0] mode_tbl [4];
        mode_tbl = '{16'hFFFA, 16'h000A, 16'hFFF4, 16'hA000};

        rst_n = 1'b0;
        bus.in_valid_i = 1'b0; bus.const_i = '0; bus.mode_i = '0; bus.out_ready_i = 1'b0;
        bus16.in_valid_i = 1'b0; bus16.const_i = '0; bus16.mode_i = '0; bus16.out_ready_i = 1'b1;
        #12;
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_const", 32'(bus.const_o), 32'd0);
        check("rst_ovf", 32'(bus.ovf_o), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        check("rst_xfer", 32'(bus.xfer_cnt_o), 32'd0);
        #11 rst_n = 1'b1;

        // All four modes on 4'b1010, one per cycle.
        for (int m = 0; m < 4; m++) begin
            cycle(1'b1, 4'hA, 2'(m), 1'b1);
            if (m > 0) begin
                check("mode_data", 32'(bus.const_o), 32'(mode_tbl[m-1]));
                check("mode_ovf", 32'(bus.ovf_o), 32'd0);
            end
        end
        cycle(1'b0, 4'h0, 2'b00, 1'b1);
        check("mode_data", 32'(bus.const_o), 32'(mode_tbl[3]));
        drain();

        // Shift overflow on the 16-bit instance.
        @(negedge clk);
        bus16.in_valid_i = 1'b1; bus16.const_i = 16'h4000; bus16.mode_i = 2'b10;
        @(negedge clk);
        e = ref_ext(64'h4000, 2, 16, 16, 1);
        check("ovf16_data", 32'(bus16.const_o), 32'h8000);
        check("ovf16_flag", 32'(bus16.ovf_o), 32'd1);
        check("ovf16_model", 32'(bus16.ovf_o), 32'(e.ovf));
        bus16.const_i = 16'hC000;
        @(negedge clk);
        bus16.in_valid_i = 1'b0;
        e = ref_ext(64'hC000, 2, 16, 16, 1);
        check("noovf16_data", 32'(bus16.const_o), 32'h8000);
        check("noovf16_flag", 32'(bus16.ovf_o), 32'd0);
        check("noovf16_model", 32'(bus16.const_o), 32'(e.data));

        // Backpressure: 3 and 5 land, 7 waits.
        cycle(1'b1, 4'd3, 2'b01, 1'b0);
        cycle(1'b1, 4'd5, 2'b01, 1'b0);
        cycle(1'b1, 4'd7, 2'b01, 1'b0);
        check("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
        cycle(1'b1, 4'd7, 2'b01, 1'b1);
        check("bp_first", 32'(bus.const_o), 32'h0003);
        cycle(1'b1, 4'd7, 2'b01, 1'b1);
        check("bp_second", 32'(bus.const_o), 32'h0005);
        cycle(1'b0, 4'd0, 2'b01, 1'b1);
        check("bp_third", 32'(bus.const_o), 32'h0007);
        drain();

        // Random streaming until 100 accepts.
        acc_cnt = 0;
        for (int i = 0; i < 2000 && acc_cnt < 100; i++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
            if (last_acc) acc_cnt++;
        end
        check("stream_accepts", 32'(acc_cnt), 32'd100);
        drain();

        // Asynchronous reset with both registers full.
        cycle(1'b1, 4'h1, 2'b00, 1'b0);
        cycle(1'b1, 4'h2, 2'b00, 1'b0);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        check("pre_rst_full", 32'(bus.in_ready_o), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready_o), 32'd1);
        check("arst_const", 32'(bus.const_o), 32'd0);
        check("arst_xfer", 32'(bus.xfer_cnt_o), 32'd0);
        sb.delete();
        sends = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        cycle(1'b1, 4'h9, 2'b11, 1'b1);
        cycle(1'b0, 4'h0, 2'b00, 1'b1);
        check("post_rst_valid", 32'(bus.out_valid_o), 32'd1);
        check("post_rst_data", 32'(bus.const_o), 32'h9000);
        cycle(1'b0, 4'h0, 2'b00, 1'b1);
        check("post_rst_alone", 32'(bus.out_valid_o), 32'd0);

        // Transfer counter: 5 more sends, then (when enabled) run past the wrap.
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i), 2'b01, 1'b1);
        drain();
`ifdef IMM_EXTEND_STATS_EN
        check("cnt_six", 32'(bus.xfer_cnt_o), 32'd6);
        for (int i = 0; i < 65530; i++) cycle(1'b1, 4'(i), 2'b01, 1'b1);
        drain();
        check("cnt_wrap", 32'(bus.xfer_cnt_o), 32'd0);
`else
        check("cnt_off", 32'(bus.xfer_cnt_o), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, multi-mode immediate extender for the datapath. Widens an IN_W-bit immediate to OUT_W bits using sign, zero, shifted-sign or upper-placement modes. Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so decode can stall without losing immediates. Sits between instruction decode and the ALU B-operand mux.

Parameters:
IN_W, 4, immediate input width; legal range 1..OUT_W
OUT_W, 16, extended output width
SHIFT, 1, left-shift amount for mode 2; legal range 0..OUT_W-1

Ports:
CLK  input  1  clock; all state on rising edge
RST_N  input  1  asynchronous active-low reset
IN_VALID_I  input  1  immediate present on CONST_I/MODE_I
IN_READY_O  output  1  block can accept this cycle
CONST_I  input  IN_W  raw immediate
MODE_I  input  2  00 sign, 01 zero, 10 sign+shift, 11 upper
OUT_VALID_O  output  1  CONST_O/OVF_O hold a result
OUT_READY_I  input  1  consumer takes result this cycle
CONST_O  output  OUT_W  extended immediate
OVF_O  output  1  mode 10 lost significant bits
XFER_CNT_O  output  16  completed output transfers (see Optional Feature)

Behaviour:
- Reset is one clock plus an asynchronous active-low reset: RST_N low clears all state immediately, without waiting for CLK. Outputs during and after reset: OUT_VALID_O=0, CONST_O=0, OVF_O=0, IN_READY_O=1, XFER_CNT_O=0. Reset mid-transfer discards both buffered entries.
- Extension, computed combinationally on accept and stored:
  - 00: {(OUT_W-IN_W) copies of CONST_I[IN_W-1], CONST_I}.
  - 01: {zeros, CONST_I}.
  - 10: sign-extended value << SHIFT, truncated to OUT_W.
  - 11: CONST_I in bits [OUT_W-1:OUT_W-IN_W], zeros below.
- OVF_O is 1 only in mode 10 when any bit shifted out of bit OUT_W-1 differs from the result's bit OUT_W-1. It is always 0 if IN_W+SHIFT<=OUT_W, and 0 in all other modes.
- Storage: output register (OREG) plus skid register (SREG), each with its own valid bit.
- Handshake:
  - Accept = IN_VALID_I & IN_READY_O.
  - Send = OUT_VALID_O & OUT_READY_I.
  - IN_READY_O = ~SREG.valid. It is registered-only and has no combinational path from OUT_READY_I.
- Per cycle:
  - Accept with OREG empty, or with Send and SREG empty → the data goes to OREG.
  - Accept with OREG full and no Send → the data goes to SREG.
  - Send with SREG full → SREG moves to OREG and SREG is cleared.
  - Send with no Accept and SREG empty → OREG is cleared.
  - SREG full blocks Accept, so Accept and SREG→OREG never happen in the same cycle.
- Latency: 1 cycle from Accept to OUT_VALID_O when the pipe is empty. Throughput is 1 per cycle while OUT_READY_I=1.
- CONST_O/OVF_O are stable while OUT_VALID_O=1 and OUT_READY_I=0. Order is strictly FIFO.
- IN_VALID_I with IN_READY_O=0 is ignored. The producer must hold its data.
- Parameter legality is checked at elaboration: IN_W>OUT_W or SHIFT>=OUT_W must fail elaboration.

Optional Feature:
Macro IMM_EXTEND_STATS_EN.
- Defined: XFER_CNT_O is a 16-bit counter that increments on every Send and wraps 16'hFFFF→16'h0000. Cleared by reset.
- Undefined: no counter logic; XFER_CNT_O is tied to 16'h0000.

Test Plan:
All scenarios use IN_W=4, OUT_W=16, SHIFT=1 unless stated.
- Modes with CONST_I=4'b1010, OUT_READY_I=1, one per cycle → CONST_O 16'hFFFA, 16'h000A, 16'hFFF4, 16'hA000 in order, each one cycle after accept; OVF_O=0.
- Overflow, parameters IN_W=16, OUT_W=16, SHIFT=1:
  - CONST_I=16'h4000, mode 10 → CONST_O=16'h8000, OVF_O=1.
  - CONST_I=16'hC000 → CONST_O=16'h8000, OVF_O=0.
- Backpressure: OUT_READY_I=0, offer 3, 5, 7 (mode 01) back-to-back → 3 and 5 accepted, IN_READY_O=0 from the cycle after the second accept. Raise OUT_READY_I → outputs 16'h0003, 16'h0005, 16'h0007 in order with no duplicates.
- Streaming: 100 random immediates with random OUT_READY_I → scoreboard matches every result in order; no drops.
- Reset: assert RST_N=0 asynchronously between clock edges with both registers full → OUT_VALID_O drops before the next edge and IN_READY_O=1. After release, the first new accept appears alone.
- Stats, with IMM_EXTEND_STATS_EN defined: 5 sends → XFER_CNT_O=5. Preload near wrap by 65536 sends → wraps to 0. Undefined → XFER_CNT_O stays 0.
